// File: rtl/clock_ctrl_pkg.sv
// Shared constants and state encoding for the CPU clock controller.
package clock_ctrl_pkg;

  localparam int unsigned CLK_CNT_WIDTH       = 28;
  localparam int unsigned CLK_DEFAULT_DIVISOR = 50000000;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } clk_state_e;

endpackage

// File: rtl/cpu_clock_controller_tick_counter.sv
// Divider counter: counts while enabled, wraps after divisor-1, clears on request.
module tick_counter #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  // Divisor is never 0 here; >= keeps the counter bounded even if it ever overshoots.
  assign o_wrap  = i_enable && (r_count >= (i_divisor - WIDTH'(1)));
  assign o_count = r_count;

  always_ff @(posedge clk_in) begin
    if (!reset_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU clock controller: halt/run/single-step FSM producing a divided clock-enable tick,
// a square clk_out and a loadable divisor accepted only while halted.
module cpu_clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH       = CLK_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_DIVISOR = CNT_WIDTH'(CLK_DEFAULT_DIVISOR)
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 div_valid,
  input  logic [CNT_WIDTH-1:0] div_value,
  output logic                 div_ready,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 step_done,
  output logic [1:0]           state
);

  clk_state_e           r_state;
  clk_state_e           w_next_state;
  logic [CNT_WIDTH-1:0] r_divisor;
  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_wrap;
  logic                 w_enable;
  logic                 w_clear;
  logic                 w_accept;

  assign w_accept = div_valid && (r_state == ST_HALTED);
  assign w_enable = (r_state == ST_RUN) || (r_state == ST_STEP);
  // Clearing on the way into HALTED keeps the counter at 0 for the whole halted period.
  assign w_clear  = (w_next_state == ST_HALTED);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state   <= ST_HALTED;
      r_divisor <= DEFAULT_DIVISOR;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_divisor <= (div_value == '0) ? CNT_WIDTH'(1) : div_value;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HALTED: begin
        if (halt_req)      w_next_state = ST_HALTED;
        else if (step_req) w_next_state = ST_STEP;
        else if (run_req)  w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req || !run_req) w_next_state = ST_HALTED;
      end
      ST_STEP: begin
        if (halt_req || w_wrap) w_next_state = ST_HALTED;
      end
      default: w_next_state = ST_HALTED;
    endcase
  end

  tick_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_tick_counter (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .i_enable (w_enable),
    .i_clear  (w_clear),
    .i_divisor(r_divisor),
    .o_count  (w_count),
    .o_wrap   (w_wrap)
  );

  // A reset or a halt during a step aborts it without a tick in that cycle.
  assign tick      = w_wrap && reset_n && !((r_state == ST_STEP) && halt_req);
  assign step_done = tick && (r_state == ST_STEP);
  assign clk_out   = w_enable && (w_count >= (r_divisor >> 1));
  assign div_ready = (r_state == ST_HALTED);
  assign state     = r_state;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Scoreboard bench for cpu_clock_controller: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_cpu_clock_controller;

  localparam int unsigned W = 28;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic         run_req;
  logic         step_req;
  logic         halt_req;
  logic         div_valid;
  logic [W-1:0] div_value;
  logic         div_ready;
  logic         tick;
  logic         clk_out;
  logic         step_done;
  logic [1:0]   state;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       tk;
    logic       co;
    logic       sd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_clock_controller dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .run_req  (run_req),
    .step_req (step_req),
    .halt_req (halt_req),
    .div_valid(div_valid),
    .div_value(div_value),
    .div_ready(div_ready),
    .tick     (tick),
    .clk_out  (clk_out),
    .step_done(step_done),
    .state    (state)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: one expected entry per checked cycle, compared mid-cycle.
  always @(negedge clk_in) begin
    exp_t e;
    logic exp_rdy;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_rdy = (e.st == 2'd0);
      n_checks++;
      if (state !== e.st || tick !== e.tk || clk_out !== e.co ||
          step_done !== e.sd || div_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s t=%0t state/tick/clk_out/step_done/div_ready got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                 e.name, $time, state, tick, clk_out, step_done, div_ready,
                 e.st, e.tk, e.co, e.sd, exp_rdy);
      end
    end
  end

  // Drive one cycle of inputs and optionally queue the outputs expected in that cycle.
  task automatic cyc(input bit rn, input bit run, input bit stp, input bit hlt,
                     input bit dv, input logic [W-1:0] dval, input bit chk,
                     input logic [1:0] st, input bit tk, input bit co, input bit sd,
                     input string nm);
    exp_t e;
    @(posedge clk_in);
    #1;
    reset_n   = rn;
    run_req   = run;
    step_req  = stp;
    halt_req  = hlt;
    div_valid = dv;
    div_value = dval;
    if (chk) begin
      e.name = nm;
      e.st   = st;
      e.tk   = tk;
      e.co   = co;
      e.sd   = sd;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    int guard;
    reset_n   = 1'b0;
    run_req   = 1'b0;
    step_req  = 1'b0;
    halt_req  = 1'b0;
    div_valid = 1'b0;
    div_value = '0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "pre");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "reset");

    // Divisor 4, free run: tick on every 4th RUN cycle, clk_out 0,0,1,1; load of 7 ignored.
    cyc(1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, "a_load4");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "a_runreq");
    for (int k = 0; k < 12; k++)
      cyc(1, 1, 0, 0, k == 5, 7, 1, 1, (k % 4) == 3, (k % 4) >= 2, 0, "a_run_div4");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "a_drop_run");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "a_halted");

    // Divisor 5, single step: one tick + step_done 5 cycles after the request.
    cyc(1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, "b_load5");
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "b_stepreq");
    for (int k = 0; k < 5; k++)
      cyc(1, 0, 0, 0, 0, 0, 1, 2, k == 4, k >= 2, k == 4, "b_step");
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "b_after_step");

    // Divisor 3, drop run_req with counter at 1.
    cyc(1, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, "c_load3");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "c_runreq");
    for (int k = 0; k < 5; k++)
      cyc(1, k != 4, 0, 0, 0, 0, 1, 1, (k % 3) == 2, (k % 3) >= 1, 0, "c_run_div3");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "c_halted");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "c_halted2");

    // Divisor 10, step aborted by halt in its 6th cycle; halt beats run+step while halted.
    cyc(1, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, "d_load10");
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "d_stepreq");
    for (int k = 0; k < 6; k++)
      cyc(1, 0, 0, k == 5, 0, 0, 1, 2, 0, k >= 5, 0, "d_step_abort");
    cyc(1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, "d_aborted");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "d_halt_priority");
    for (int k = 0; k < 8; k++)
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "d_no_tick");

    // Divisor 0 stored as 1: tick and clk_out high on every RUN cycle.
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "e_load0");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "e_runreq");
    for (int k = 0; k < 4; k++)
      cyc(1, 1, 0, 0, k == 1, 7, 1, 1, 1, 1, 0, "e_run_div1");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, "e_drop_run");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "e_halted");

    // Divisor 2 loaded in the same cycle as the run request applies to that run.
    cyc(1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, "g_load2_run");
    for (int k = 0; k < 4; k++)
      cyc(1, 1, 0, 0, 0, 0, 1, 1, (k % 2) == 1, (k % 2) == 1, 0, "g_run_div2");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "g_drop_run");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "g_halted");

    // Reset mid-RUN on the would-be tick cycle, then default divisor gives no early tick.
    cyc(1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, "f_load4");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "f_runreq");
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 0, 0, 0, 1, 1, 0, k >= 2, 0, "f_run_div4");
    cyc(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, "f_reset_cycle");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "f_after_reset");
    for (int k = 0; k < 10; k++)
      cyc(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "f_run_default_div");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "f_drop_run");
    cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "f_step_and_run");
    cyc(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, "f_step_wins");
    cyc(1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, "f_step_halt");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "f_halted");

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk_in);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    @(posedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
